uart_cmd_parser: RTL

- Sits directly downstream of the UART receiver, which emits one byte plus a one-cycle strobe.
- Assembles received bytes into framed commands and checks each frame.
- Issues pixel-write and clear-screen requests toward the VGA framebuffer side.
- Decouples byte-rate serial input from framebuffer back-pressure with a valid/ready handshake.

---
 rtl/uart_cmd_parser_if.sv | 34 +++
 rtl/uart_cmd_parser.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser_if.sv
// Byte-strobe input and pixel/clear request bundle of uart_cmd_parser.
// UART_CMD_ACK_EN adds the ACK/NAK byte returned toward the UART transmitter.
interface uart_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       pix_valid;
  logic       pix_ready;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [7:0] pix_color;
  logic       clr_pulse;
  logic [7:0] err_cnt;
  logic       busy;
`ifdef UART_CMD_ACK_EN
  logic [7:0] ack_data;
  logic       ack_valid;
`endif

  modport master (
    output rx_data, rx_valid, pix_ready,
    input  pix_valid, pix_x, pix_y, pix_color, clr_pulse, err_cnt, busy
`ifdef UART_CMD_ACK_EN
    , input ack_data, ack_valid
`endif
  );

  modport slave (
    input  rx_data, rx_valid, pix_ready,
    output pix_valid, pix_x, pix_y, pix_color, clr_pulse, err_cnt, busy
`ifdef UART_CMD_ACK_EN
    , output ack_data, ack_valid
`endif
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Frames UART bytes (0x55, OPC, payload, XOR checksum) into pixel-write / clear requests.
// Optional macro UART_CMD_ACK_EN adds ACK (0x06) / NAK (0x15) reporting.
module uart_cmd_parser #(
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479,
  parameter int TIMEOUT = 50000
) (
  input logic             clock50,
  input logic             reset,
  uart_cmd_parser_if.slave bus
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_OPC, S_PAYLOAD, S_CHK, S_ISSUE} state_t;

  state_t             r_state;
  logic               r_is_pix;
  logic [2:0]         r_cnt;
  logic [7:0]         r_chk;
  logic [39:0]        r_sh;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_pix_valid;
  logic               r_clr;
  logic [9:0]         r_pix_x;
  logic [9:0]         r_pix_y;
  logic [7:0]         r_pix_color;
  logic [7:0]         r_err;
`ifdef UART_CMD_ACK_EN
  logic               r_ack_valid;
  logic [7:0]         r_ack_data;
`endif

  logic       w_in_frame;
  logic       w_tmo_hit;
  logic [9:0] w_x;
  logic [9:0] w_y;
  logic       w_frame_ok;
  logic       w_bad_opc;
  logic       w_bad_frame;
  logic       w_overrun;
  logic       w_nak;
  logic       w_err_inc;
  logic       w_hs;

  // Payload shift register after a 'P' frame: x_hi, x_lo, y_hi, y_lo, color (MSB first).
  always_comb begin
    w_in_frame  = (r_state == S_OPC) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
    w_tmo_hit   = w_in_frame && !bus.rx_valid && (r_tmo == TMO_W'(TIMEOUT - 1));
    w_x         = {r_sh[33:32], r_sh[31:24]};
    w_y         = {r_sh[17:16], r_sh[15:8]};
    w_frame_ok  = (bus.rx_data == r_chk) &&
                  (!r_is_pix || ((r_sh[39:34] == 6'd0) && (r_sh[23:18] == 6'd0) &&
                                 (w_x <= 10'(X_MAX)) && (w_y <= 10'(Y_MAX))));
    w_bad_opc   = (r_state == S_OPC) && bus.rx_valid &&
                  (bus.rx_data != 8'h50) && (bus.rx_data != 8'h43);
    w_bad_frame = (r_state == S_CHK) && bus.rx_valid && !w_frame_ok;
    w_overrun   = (r_state == S_ISSUE) && bus.rx_valid;
    w_nak       = w_tmo_hit || w_bad_opc || w_bad_frame;
    w_err_inc   = w_nak || w_overrun;
    w_hs        = r_pix_valid && bus.pix_ready;
  end

  always_ff @(posedge clock50) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_is_pix    <= 1'b0;
      r_cnt       <= 3'd0;
      r_chk       <= 8'd0;
      r_sh        <= 40'd0;
      r_tmo       <= '0;
      r_pix_valid <= 1'b0;
      r_clr       <= 1'b0;
      r_pix_x     <= 10'd0;
      r_pix_y     <= 10'd0;
      r_pix_color <= 8'd0;
      r_err       <= 8'd0;
`ifdef UART_CMD_ACK_EN
      r_ack_valid <= 1'b0;
      r_ack_data  <= 8'd0;
`endif
    end else begin
      r_clr <= 1'b0;
`ifdef UART_CMD_ACK_EN
      r_ack_valid <= 1'b0;
      if (w_nak) begin
        r_ack_valid <= 1'b1;
        r_ack_data  <= 8'h15;
      end
`endif
      if (w_err_inc && (r_err != 8'hFF))
        r_err <= r_err + 8'd1;

      if (w_in_frame)
        r_tmo <= bus.rx_valid ? '0 : r_tmo + 1'b1;
      else
        r_tmo <= '0;

      case (r_state)
        S_IDLE: begin
          if (bus.rx_valid && (bus.rx_data == 8'h55))
            r_state <= S_OPC;
        end
        S_OPC: begin
          if (w_tmo_hit) begin
            r_state <= S_IDLE;
          end else if (bus.rx_valid) begin
            r_chk <= bus.rx_data;
            if (bus.rx_data == 8'h50) begin
              r_is_pix <= 1'b1;
              r_cnt    <= 3'd5;
              r_state  <= S_PAYLOAD;
            end else if (bus.rx_data == 8'h43) begin
              r_is_pix <= 1'b0;
              r_cnt    <= 3'd1;
              r_state  <= S_PAYLOAD;
            end else begin
              r_state  <= S_IDLE;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_tmo_hit) begin
            r_state <= S_IDLE;
          end else if (bus.rx_valid) begin
            r_sh  <= {r_sh[31:0], bus.rx_data};
            r_chk <= r_chk ^ bus.rx_data;
            r_cnt <= r_cnt - 3'd1;
            if (r_cnt == 3'd1)
              r_state <= S_CHK;
          end
        end
        S_CHK: begin
          if (w_tmo_hit) begin
            r_state <= S_IDLE;
          end else if (bus.rx_valid) begin
            if (w_frame_ok) begin
              r_state     <= S_ISSUE;
              r_pix_color <= r_sh[7:0];
              if (r_is_pix) begin
                r_pix_valid <= 1'b1;
                r_pix_x     <= w_x;
                r_pix_y     <= w_y;
              end else begin
                r_clr <= 1'b1;
              end
`ifdef UART_CMD_ACK_EN
              r_ack_data  <= 8'h06;
              r_ack_valid <= !r_is_pix;
`endif
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_ISSUE: begin
          // A pixel request waits for the handshake; a clear lasts exactly one cycle.
          if (!r_is_pix) begin
            r_state <= S_IDLE;
          end else if (w_hs) begin
            r_pix_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pix_valid = r_pix_valid;
  assign bus.pix_x     = r_pix_x;
  assign bus.pix_y     = r_pix_y;
  assign bus.pix_color = r_pix_color;
  assign bus.clr_pulse = r_clr;
  assign bus.err_cnt   = r_err;
  assign bus.busy      = (r_state != S_IDLE);
`ifdef UART_CMD_ACK_EN
  // The pixel ACK must coincide with the handshake, so it is combined with the handshake term.
  assign bus.ack_valid = r_ack_valid || w_hs;
  assign bus.ack_data  = r_ack_data;
`endif
endmodule
